// File: rtl/fetch_decode_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_decode_ctrl
//   Multi-cycle fetch/decode sequencer for an RV32I core. It issues one
//   instruction fetch at a time over a valid/ready memory port. The returned
//   word is classified by opcode and held as a decoded bundle on a valid/ready
//   output until the execute stage takes it. Branch/jump redirects reload the
//   PC. A redirect that arrives while a fetch is in flight is remembered, and
//   the stale response is dropped when it returns.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_imem_req_valid    fetch request valid
//   o_imem_req_addr     fetch address (current PC), stable until accepted
//   i_imem_req_ready    memory accepts request
//   i_imem_rsp_valid    instruction word valid (one per accepted request)
//   i_imem_rsp_data     instruction word
//   i_redirect_valid    taken branch/jump
//   i_redirect_addr     redirect target, bits [1:0] dropped
//   o_dec_valid         decoded bundle valid
//   i_dec_ready         execute stage accepts bundle
//   o_dec_instr         latched instruction word
//   o_dec_pc            PC of o_dec_instr
//   o_imm_type          immediate format: 01=I 10=S 11=B 00=J
//   o_imm_en            instruction uses o_imm_type
//   o_illegal           opcode not supported (qualified by o_dec_valid)
//   o_instr_count       completed decode handshakes, wraps
// ----------------------------------------------------------------------------
module fetch_decode_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_addr,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_dec_instr,
    output logic [31:0] o_dec_pc,
    output logic [1:0]  o_imm_type,
    output logic        o_imm_en,
    output logic        o_illegal,
    output logic [31:0] o_instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_redir_pending;
    logic [31:0] r_redir_addr;

    // A redirect arriving this cycle beats any older pending one.
    logic        w_redir_any;
    logic [31:0] w_redir_tgt;
    logic [1:0]  w_imm_type;
    logic        w_imm_en;
    logic        w_illegal;

    always_comb begin
        w_redir_any = i_redirect_valid | r_redir_pending;
        w_redir_tgt = (i_redirect_valid ? i_redirect_addr : r_redir_addr) & 32'hFFFF_FFFC;
    end

    // Opcode classification of the incoming response word; registered
    // together with the word itself when the bundle is latched.
    always_comb begin
        w_imm_type = 2'b00;
        w_imm_en   = 1'b0;
        w_illegal  = 1'b0;
        case (i_imem_rsp_data[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w_imm_type = 2'b01;
                w_imm_en   = 1'b1;
            end
            7'b0100011: begin
                w_imm_type = 2'b10;
                w_imm_en   = 1'b1;
            end
            7'b1100011: begin
                w_imm_type = 2'b11;
                w_imm_en   = 1'b1;
            end
            7'b1101111: begin
                w_imm_type = 2'b00;
                w_imm_en   = 1'b1;
            end
            7'b0110011, 7'b0110111, 7'b0010111, 7'b1110011: begin
                w_imm_type = 2'b00;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign o_imem_req_addr = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_pc             <= {RESET_PC[31:2], 2'b00};
            r_redir_pending  <= 1'b0;
            r_redir_addr     <= 32'h0;
            o_imem_req_valid <= 1'b0;
            o_dec_valid      <= 1'b0;
            o_dec_instr      <= 32'h0;
            o_dec_pc         <= 32'h0;
            o_imm_type       <= 2'b00;
            o_imm_en         <= 1'b0;
            o_illegal        <= 1'b0;
            o_instr_count    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_imem_req_valid <= 1'b1;
                    r_state          <= S_REQ;
                end
                S_REQ: begin
                    // The request address stays put; a redirect here only
                    // marks the coming response as stale.
                    if (i_redirect_valid) begin
                        r_redir_pending <= 1'b1;
                        r_redir_addr    <= w_redir_tgt;
                    end
                    if (i_imem_req_ready) begin
                        o_imem_req_valid <= 1'b0;
                        r_state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_redirect_valid) begin
                        r_redir_pending <= 1'b1;
                        r_redir_addr    <= w_redir_tgt;
                    end
                    if (i_imem_rsp_valid) begin
                        if (w_redir_any) begin
                            // Stale fetch: drop it and refetch at the target.
                            r_pc             <= w_redir_tgt;
                            r_redir_pending  <= 1'b0;
                            o_imem_req_valid <= 1'b1;
                            r_state          <= S_REQ;
                        end else begin
                            o_dec_instr <= i_imem_rsp_data;
                            o_dec_pc    <= r_pc;
                            o_imm_type  <= w_imm_type;
                            o_imm_en    <= w_imm_en;
                            o_illegal   <= w_illegal;
                            o_dec_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_dec_ready) begin
                        o_instr_count    <= o_instr_count + 32'd1;
                        r_pc             <= w_redir_any ? w_redir_tgt : o_dec_pc + 32'd4;
                        r_redir_pending  <= 1'b0;
                        o_dec_valid      <= 1'b0;
                        o_imem_req_valid <= 1'b1;
                        r_state          <= S_REQ;
                    end else if (w_redir_any) begin
                        // Flush the held bundle without counting it.
                        r_pc             <= w_redir_tgt;
                        r_redir_pending  <= 1'b0;
                        o_dec_valid      <= 1'b0;
                        o_imem_req_valid <= 1'b1;
                        r_state          <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
